// File: rtl/offset14_to_float32.sv
// rtl/offset14_to_float32.sv - 14-bit offset-binary ADC code to IEEE-754 single, 3-stage pipeline
//
// Converts each accepted offset-binary code to (code - 8192) * 2^-SCALE_SHIFT
// as an IEEE-754 single-precision float.
//
// Ports:
//   aclk     in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   s_valid  in   1   input sample valid
//   s_ready  out  1   sample accepted this cycle when s_valid is also high
//   s_code   in  14   offset-binary code (0 = most negative, 8192 = zero)
//   m_valid  out  1   output float valid
//   m_ready  in   1   downstream accepts the output
//   m_float  out 32   IEEE-754 single result
//   m_clip   out  1   sample was a rail code (0 or 16383), aligned with m_float

module offset14_to_float32 #(
    parameter int SCALE_SHIFT  = 13,
    parameter bit CLIP_FLAG_EN = 1'b1
) (
    input  logic        aclk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [13:0] s_code,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_float,
    output logic        m_clip
);

    // Biased exponent for a magnitude whose leading one is at bit 0.
    // SCALE_SHIFT is limited to 0..100, so this stays within 27..127.
    localparam logic [7:0] EXP_BIAS = 8'(127 - SCALE_SHIFT);

    localparam logic [13:0] CODE_ZERO = 14'd8192;
    localparam logic [13:0] CODE_MAX  = 14'h3FFF;

    // Single advance enable for the whole pipeline; bubbles travel with it.
    logic ce;

    // Stage 1: sign / magnitude / rail detect
    logic        valid1_q, valid1_d;
    logic        sign1_q,  sign1_d;
    logic [13:0] mag1_q,   mag1_d;
    logic        clip1_q,  clip1_d;

    // Stage 2: zero detect and leading-one position
    logic        valid2_q, valid2_d;
    logic        sign2_q,  sign2_d;
    logic [13:0] mag2_q,   mag2_d;
    logic        clip2_q,  clip2_d;
    logic        zero2_q,  zero2_d;
    logic [3:0]  lead2_q,  lead2_d;

    // Stage 3: packed float
    logic        valid3_q, valid3_d;
    logic [31:0] float3_q, float3_d;
    logic        clip3_q,  clip3_d;

    // Combinational helpers
    logic        in_sign;
    logic [13:0] in_mag;
    logic        in_clip;
    logic [3:0]  lead_enc;
    logic [22:0] mantissa;
    logic [7:0]  exponent;

    assign ce      = ~valid3_q | m_ready;
    assign s_ready = ce;

    // ------------------------------------------------------------------
    // Stage 1 next-state
    // ------------------------------------------------------------------
    always_comb begin
        // v = code - 8192 is negative exactly when bit 13 of the code is clear.
        // Both subtractions stay within 14 bits: |v| peaks at 8192 (code 0).
        in_sign = ~s_code[13];
        in_mag  = in_sign ? (CODE_ZERO - s_code) : (s_code - CODE_ZERO);
        in_clip = (s_code == 14'd0) || (s_code == CODE_MAX);

        valid1_d = valid1_q;
        sign1_d  = sign1_q;
        mag1_d   = mag1_q;
        clip1_d  = clip1_q;
        if (ce) begin
            valid1_d = s_valid;
            sign1_d  = in_sign;
            mag1_d   = in_mag;
            clip1_d  = in_clip;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 next-state
    // ------------------------------------------------------------------
    always_comb begin
        // Priority encoder: the highest set bit wins because it is visited last.
        lead_enc = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (mag1_q[i]) begin
                lead_enc = 4'(i);
            end
        end

        valid2_d = valid2_q;
        sign2_d  = sign2_q;
        mag2_d   = mag2_q;
        clip2_d  = clip2_q;
        zero2_d  = zero2_q;
        lead2_d  = lead2_q;
        if (ce) begin
            valid2_d = valid1_q;
            sign2_d  = sign1_q;
            mag2_d   = mag1_q;
            clip2_d  = clip1_q;
            zero2_d  = (mag1_q == 14'd0);
            lead2_d  = lead_enc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 next-state
    // ------------------------------------------------------------------
    always_comb begin
        // Left-justify the leading one into bit 23; it falls off the 23-bit
        // field, which drops the hidden bit. At most 14 significant bits, so
        // the result is exact with no rounding.
        mantissa = {9'd0, mag2_q} << (5'd23 - {1'b0, lead2_q});
        exponent = EXP_BIAS + {4'd0, lead2_q};

        valid3_d = valid3_q;
        float3_d = float3_q;
        clip3_d  = clip3_q;
        if (ce) begin
            valid3_d = valid2_q;
            // Zero is always emitted as +0.0 regardless of the sign flag.
            float3_d = zero2_q ? 32'h0000_0000 : {sign2_q, exponent, mantissa};
            clip3_d  = CLIP_FLAG_EN ? clip2_q : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q <= 1'b0;
            sign1_q  <= 1'b0;
            mag1_q   <= 14'd0;
            clip1_q  <= 1'b0;
            valid2_q <= 1'b0;
            sign2_q  <= 1'b0;
            mag2_q   <= 14'd0;
            clip2_q  <= 1'b0;
            zero2_q  <= 1'b0;
            lead2_q  <= 4'd0;
            valid3_q <= 1'b0;
            float3_q <= 32'h0000_0000;
            clip3_q  <= 1'b0;
        end else begin
            valid1_q <= valid1_d;
            sign1_q  <= sign1_d;
            mag1_q   <= mag1_d;
            clip1_q  <= clip1_d;
            valid2_q <= valid2_d;
            sign2_q  <= sign2_d;
            mag2_q   <= mag2_d;
            clip2_q  <= clip2_d;
            zero2_q  <= zero2_d;
            lead2_q  <= lead2_d;
            valid3_q <= valid3_d;
            float3_q <= float3_d;
            clip3_q  <= clip3_d;
        end
    end

    assign m_valid = valid3_q;
    assign m_float = float3_q;
    assign m_clip  = clip3_q;

endmodule

// File: tb/tb_offset14_to_float32.sv
// tb/tb_offset14_to_float32.sv - directed and random bench for offset14_to_float32
module tb_offset14_to_float32;

    logic        aclk;
    logic        rst_n;
    logic        s_valid;
    logic [13:0] s_code;
    logic        m_ready;

    logic        s_ready13, m_valid13, m_clip13;
    logic [31:0] m_float13;
    logic        s_ready0, m_valid0, m_clip0;
    logic [31:0] m_float0;

    int vectors;
    int miscompares;
    int cycle;

    bit          mon_en;
    logic [31:0] q13_f[$];
    logic        q13_c[$];
    logic [31:0] q0_f[$];
    logic        q0_c[$];
    int          q_cyc[$];

    offset14_to_float32 #(.SCALE_SHIFT(13), .CLIP_FLAG_EN(1'b1)) dut13 (
        .aclk(aclk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready13), .s_code(s_code),
        .m_valid(m_valid13), .m_ready(m_ready), .m_float(m_float13), .m_clip(m_clip13)
    );

    offset14_to_float32 #(.SCALE_SHIFT(0), .CLIP_FLAG_EN(1'b1)) dut0 (
        .aclk(aclk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready0), .s_code(s_code),
        .m_valid(m_valid0), .m_ready(m_ready), .m_float(m_float0), .m_clip(m_clip0)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle <= cycle + 1;

    // A transfer happens on the next rising edge when valid and ready are both high here.
    always @(negedge aclk) begin
        if (mon_en && m_valid13 && m_ready) begin
            q13_f.push_back(m_float13);
            q13_c.push_back(m_clip13);
            q_cyc.push_back(cycle);
        end
        if (mon_en && m_valid0 && m_ready) begin
            q0_f.push_back(m_float0);
            q0_c.push_back(m_clip0);
        end
    end

    // Independent reference: real arithmetic, then double -> single repack.
    function automatic logic [31:0] ref_float(input logic [13:0] c, input int sh);
        int          v;
        real         r;
        logic [63:0] d;
        v = int'(c) - 8192;
        if (v == 0) return 32'h0000_0000;
        r = real'(v);
        for (int k = 0; k < sh; k++) r = r / 2.0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    task automatic clear_queues();
        q13_f.delete(); q13_c.delete(); q0_f.delete(); q0_c.delete(); q_cyc.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_code(input logic [13:0] c);
        bit got;
        got = 1'b0;
        s_valid = 1'b1;
        s_code  = c;
        for (int k = 0; k < 300; k++) begin
            @(negedge aclk);
            if (s_ready13) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            miscompares++;
            $display("FAIL send_timeout code=%0d s_ready never rose", c);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int k = 0; k < 3000; k++) begin
            if (q13_f.size() >= n) break;
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_code  = 14'd100;
        m_ready = 1'b1;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        vectors++;
        if (m_valid13 !== 1'b0 || m_float13 !== 32'h0 || m_clip13 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b f=%h c=%b need v=0 f=00000000 c=0", m_valid13, m_float13, m_clip13);
        end
        vectors++;
        if (m_valid0 !== 1'b0 || m_float0 !== 32'h0 || m_clip0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs_s0 got v=%b f=%h c=%b need v=0 f=00000000 c=0", m_valid0, m_float0, m_clip0);
        end
        @(posedge aclk);
        #1;
        rst_n   = 1'b1;
        s_code  = 14'd8192;
        s_valid = 1'b1;
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge aclk);
            vectors++;
            if (m_valid13 !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early cyc%0d got m_valid=%b need 0", j + 1, m_valid13);
            end
        end
        @(negedge aclk);
        vectors++;
        if (m_valid13 !== 1'b1 || m_float13 !== 32'h0000_0000 || m_clip13 !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_3 got v=%b f=%h c=%b need v=1 f=00000000 c=0", m_valid13, m_float13, m_clip13);
        end
    endtask

    task automatic test_scale0_back_to_back();
        logic [13:0] codes[4];
        logic [31:0] exp0[4];
        logic [31:0] exp13[4];
        logic        expc[4];
        codes = '{14'd16383, 14'd0, 14'd8193, 14'd8191};
        exp0  = '{32'h45FFF800, 32'hC6000000, 32'h3F800000, 32'hBF800000};
        exp13 = '{32'h3F7FF800, 32'hBF800000, 32'h39000000, 32'hB9000000};
        expc  = '{1'b1, 1'b1, 1'b0, 1'b0};
        @(posedge aclk);
        #1;
        clear_queues();
        mon_en  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_code(codes[i]);
        wait_outputs(4);
        repeat (4) @(negedge aclk);
        vectors++;
        if (q0_f.size() != 4 || q13_f.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_count got %0d/%0d need 4/4", q0_f.size(), q13_f.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (q0_f[i] !== exp0[i] || q0_c[i] !== expc[i]) begin
                    miscompares++;
                    $display("FAIL s0_b2b[%0d] got %h clip=%b need %h clip=%b", i, q0_f[i], q0_c[i], exp0[i], expc[i]);
                end
                vectors++;
                if (q13_f[i] !== exp13[i] || q13_c[i] !== expc[i]) begin
                    miscompares++;
                    $display("FAIL s13_b2b[%0d] got %h clip=%b need %h clip=%b", i, q13_f[i], q13_c[i], exp13[i], expc[i]);
                end
                vectors++;
                if (q_cyc[i] != q_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d] got cycle %0d need %0d", i, q_cyc[i], q_cyc[0] + i);
                end
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_scale13();
        logic [13:0] codes[4];
        logic [31:0] exp13[4];
        logic        expc[4];
        codes = '{14'd0, 14'd16383, 14'd8193, 14'd8192};
        exp13 = '{32'hBF800000, 32'h3F7FF800, 32'h39000000, 32'h00000000};
        expc  = '{1'b1, 1'b1, 1'b0, 1'b0};
        @(posedge aclk);
        #1;
        clear_queues();
        mon_en  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_code(codes[i]);
            repeat (2) begin @(posedge aclk); #1; end
        end
        wait_outputs(4);
        repeat (4) @(negedge aclk);
        vectors++;
        if (q13_f.size() != 4) begin
            miscompares++;
            $display("FAIL s13_count got %0d need 4", q13_f.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (q13_f[i] !== exp13[i] || q13_c[i] !== expc[i]) begin
                    miscompares++;
                    $display("FAIL s13_vec[%0d] got %h clip=%b need %h clip=%b", i, q13_f[i], q13_c[i], exp13[i], expc[i]);
                end
            end
            vectors++;
            if (q0_f[3] !== 32'h0000_0000) begin
                miscompares++;
                $display("FAIL s0_zero got %h need 00000000", q0_f[3]);
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] expf[8];
        bit          seen;
        expf = '{32'h39000000, 32'h39800000, 32'h39C00000, 32'h3A000000,
                 32'h3A200000, 32'h3A400000, 32'h3A600000, 32'h3A800000};
        @(posedge aclk);
        #1;
        clear_queues();
        mon_en  = 1'b1;
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_code(14'(8193 + i));
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge aclk);
                    if (m_valid13) begin
                        seen = 1'b1;
                        break;
                    end
                end
                vectors++;
                if (!seen) begin
                    miscompares++;
                    $display("FAIL bp_first_output got none need m_valid within 50 cycles");
                end
                for (int j = 0; j < 6; j++) begin
                    vectors++;
                    if (m_valid13 !== 1'b1 || m_float13 !== expf[0] || s_ready13 !== 1'b0) begin
                        miscompares++;
                        $display("FAIL bp_hold[%0d] got v=%b f=%h s_ready=%b need v=1 f=%h s_ready=0",
                                 j, m_valid13, m_float13, s_ready13, expf[0]);
                    end
                    @(negedge aclk);
                end
                @(posedge aclk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_outputs(8);
        repeat (6) @(negedge aclk);
        vectors++;
        if (q13_f.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count got %0d need 8", q13_f.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (q13_f[i] !== expf[i]) begin
                    miscompares++;
                    $display("FAIL bp_order[%0d] got %h need %h", i, q13_f[i], expf[i]);
                end
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 150;
        logic [13:0] sent[$];
        bit          done;
        logic [31:0] e13, e0;
        logic        ec;
        @(posedge aclk);
        #1;
        clear_queues();
        mon_en = 1'b1;
        done   = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    int sel;
                    logic [13:0] c;
                    repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                    sel = $urandom_range(0, 9);
                    case (sel)
                        0:       c = 14'd0;
                        1:       c = 14'd16383;
                        2:       c = 14'd8192;
                        default: c = 14'($urandom_range(0, 16383));
                    endcase
                    send_code(c);
                    sent.push_back(c);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        wait_outputs(N);
        repeat (10) @(negedge aclk);
        vectors++;
        if (q13_f.size() != N || q0_f.size() != N) begin
            miscompares++;
            $display("FAIL rand_count got %0d/%0d need %0d", q13_f.size(), q0_f.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                e13 = ref_float(sent[i], 13);
                e0  = ref_float(sent[i], 0);
                ec  = (sent[i] == 14'd0) || (sent[i] == 14'd16383);
                vectors++;
                if (q13_f[i] !== e13 || q13_c[i] !== ec) begin
                    miscompares++;
                    $display("FAIL rand13[%0d] code=%0d got %h clip=%b need %h clip=%b", i, sent[i], q13_f[i], q13_c[i], e13, ec);
                end
                vectors++;
                if (q0_f[i] !== e0) begin
                    miscompares++;
                    $display("FAIL rand0[%0d] code=%0d got %h need %h", i, sent[i], q0_f[i], e0);
                end
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        @(posedge aclk);
        #1;
        clear_queues();
        mon_en  = 1'b1;
        m_ready = 1'b1;
        send_code(14'd9000);
        send_code(14'd100);
        send_code(14'd16383);
        vectors++;
        if (m_valid13 !== 1'b1) begin
            miscompares++;
            $display("FAIL flight_full got m_valid=%b need 1", m_valid13);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid13 !== 1'b0 || m_float13 !== 32'h0 || m_clip13 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b f=%h c=%b need v=0 f=00000000 c=0", m_valid13, m_float13, m_clip13);
        end
        repeat (2) @(posedge aclk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge aclk);
        vectors++;
        if (q13_f.size() != 0 || q0_f.size() != 0) begin
            miscompares++;
            $display("FAIL stale_outputs got %0d/%0d need 0", q13_f.size(), q0_f.size());
        end
        mon_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        mon_en      = 1'b0;
        s_valid     = 1'b0;
        s_code      = 14'd0;
        m_ready     = 1'b1;
        rst_n       = 1'b0;
        test_reset();
        test_scale0_back_to_back();
        test_scale13();
        test_backpressure();
        test_random();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/offset14_to_float32.md
Name: offset14_to_float32

Overview:
- Receive-path counterpart of the float32-to-offset-binary DAC converter.
- Takes 14-bit offset-binary ADC sample codes and converts each to an IEEE-754 single-precision float, optionally scaled by 2^-SCALE_SHIFT.
- 3-stage pipeline with valid/ready handshakes on both sides; sits between the ADC capture logic and float DSP blocks (FFT, measurement).

Parameters:
- SCALE_SHIFT, 13, output = (code-8192) * 2^-SCALE_SHIFT. Legal range 0..100; 13 maps full scale to [-1.0, +0.99987793].
- CLIP_FLAG_EN, 1, when 1 m_clip reports rail codes; when 0 m_clip is tied 0.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block accepts a sample this cycle.
- s_code  in  14  offset-binary code: 0 = most negative, 8192 = zero, 16383 = most positive.
- m_valid  out  1  output float valid.
- m_ready  in  1  downstream accepts the output.
- m_float  out  32  IEEE-754 single result.
- m_clip  out  1  sample was a rail code (0 or 16383); aligned with m_float.

Behaviour:
- Reset: while rst_n=0, all stage valids=0, m_valid=0, m_float=0x00000000, m_clip=0. Reset asserted mid-operation discards in-flight samples. First acceptance is possible in the cycle after rst_n deasserts.
- Advance enable: ce = ~m_valid | m_ready. s_ready = ce (combinational).
  - When ce=1, every stage register loads from the previous stage. Stage1 valid loads s_valid.
  - When ce=0, all stages hold and no input is accepted.
  - Bubbles are not compressed.
- Latency: 3 aclk cycles from the accept cycle (s_valid & s_ready) to m_valid, when no stall occurs. Throughput is 1 sample/cycle while m_ready=1.
- m_float and m_clip are stable while m_valid=1 and m_ready=0.
- Stage1: capture the code.
  - v = code - 8192, signed 15-bit, range -8192..8191.
  - sign = v<0; mag = |v|, 14-bit unsigned, max 8192.
  - clip = (code==0) | (code==16383).
- Stage2:
  - zero = (mag==0).
  - lead = index of highest set bit of mag, 0..13, from a priority encoder.
  - Pass mag, sign and clip forward.
- Stage3: pack the result.
  - If zero: m_float = 0x00000000 (always +0.0; sign bit cleared).
  - Otherwise:
    - exponent = 127 + lead - SCALE_SHIFT, 8-bit.
    - mantissa = (mag << (23-lead))[22:0], with the hidden bit dropped.
    - m_float = {sign, exponent, mantissa}.
  - Conversion is exact: mag has ≤14 significant bits, so no rounding is needed.
  - No NaN, Inf or denormal outputs are possible within the legal SCALE_SHIFT range.
- Simultaneous events: with m_valid=1, m_ready=1 and s_valid=1 in the same cycle, the output is consumed and the new sample enters the pipeline in that cycle, with no lost cycle.
- s_code is sampled only when s_valid & s_ready; it is don't-care otherwise.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with s_valid=1 -> m_valid=0, m_float=0, m_clip=0. Release, send code 8192 -> 3 cycles later m_valid=1, m_float=0x00000000.
- SCALE_SHIFT=0, m_ready=1, back-to-back codes 16383, 0, 8193, 8191 -> outputs on consecutive cycles:
  - 0x45FFF800 clip=1
  - 0xC6000000 clip=1
  - 0x3F800000 clip=0
  - 0xBF800000 clip=0
- SCALE_SHIFT=13:
  - code 0 -> 0xBF800000.
  - code 16383 -> 0x3F7FF800.
  - code 8193 -> 0x39000000.
  - code 8192 -> 0x00000000.
- Backpressure: stream codes 8193..8200, hold m_ready=0 for 6 cycles after the first output -> s_ready=0 while the pipeline is full, m_float held at the first value. All 8 outputs appear in order after release, with none dropped or duplicated.
- Random full-range codes with random s_valid/m_ready, checked against a reference model of (code-8192)*2^-13 as float32 -> bit-exact match, and output count equals input count.
- Assert rst_n=0 while 3 samples are in flight -> m_valid drops immediately (asynchronous). After release, no stale outputs appear.
